// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shift/rotate unit. SRL, SRA, SLL and ROR with 5-bit
// amounts, built on a single right-only barrel shifter (bs). SLL reverses
// the bits going in and coming out. ROR with a nonzero amount takes two
// passes: a right shift by n, then a left shift by 16-n, ORed together.

// Combinational 16-bit right shifter: b = a >> s, vacated bits filled with l.
module bs (
  input  logic [15:0] a,
  input  logic [3:0]  s,
  input  logic        l,
  output logic [15:0] b
);

  logic [15:0] st0;
  logic [15:0] st1;
  logic [15:0] st2;

  // Four log-stages, one per amount bit.
  always_comb begin
    st0 = s[0] ? {l, a[15:1]}             : a;
    st1 = s[1] ? {{2{l}}, st0[15:2]}      : st0;
    st2 = s[2] ? {{4{l}}, st1[15:4]}      : st1;
    b   = s[3] ? {{8{l}}, st2[15:8]}      : st2;
  end

endmodule

module shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] din,
  input  logic [4:0]  amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] dout,
  output logic        busy
);

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned SW = 4;
  localparam int unsigned OW = 2;

  localparam logic [OW-1:0] OP_SRL = 2'b00;
  localparam logic [OW-1:0] OP_SRA = 2'b01;
  localparam logic [OW-1:0] OP_SLL = 2'b10;
  localparam logic [OW-1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] op_q, op_d;
  logic [W-1:0]  din_q, din_d;
  logic [AW-1:0] amt_q, amt_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          out_valid_q, out_valid_d;

  logic [W-1:0]  bs_a;
  logic [SW-1:0] bs_s;
  logic          bs_l;
  logic [W-1:0]  bs_b;

  logic [SW-1:0] rot_n;
  logic          two_pass;
  logic          sat_fill;
  logic [W-1:0]  p1_result;

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) begin
      r[i] = x[W-1-i];
    end
    return r;
  endfunction

  bs u_bs (
    .a (bs_a),
    .s (bs_s),
    .l (bs_l),
    .b (bs_b)
  );

  // Shifter operand selection: P2 does the left half of a rotate, otherwise
  // the latched op decides data orientation and fill bit.
  always_comb begin
    rot_n    = amt_q[SW-1:0];
    two_pass = (op_q == OP_ROR) && (rot_n != '0);
    bs_a     = din_q;
    bs_s     = rot_n;
    bs_l     = 1'b0;
    if (state_q == P2) begin
      bs_a = rev(din_q);
      bs_s = SW'(AW'(W) - {1'b0, rot_n});
    end else begin
      unique case (op_q)
        OP_SRA:  bs_l = din_q[W-1];
        OP_SLL:  bs_a = rev(din_q);
        default: ;
      endcase
    end
  end

  // Single-pass result, including saturation for amounts of 16 and above.
  always_comb begin
    sat_fill  = (op_q == OP_SRA) & din_q[W-1];
    p1_result = bs_b;
    unique case (op_q)
      OP_SRL, OP_SRA: p1_result = bs_b;
      OP_SLL:         p1_result = rev(bs_b);
      OP_ROR:         p1_result = din_q;
      default:        p1_result = bs_b;
    endcase
    if ((op_q != OP_ROR) && amt_q[AW-1]) begin
      p1_result = {W{sat_fill}};
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    din_d       = din_q;
    amt_d       = amt_q;
    t_d         = t_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = op;
          din_d   = din;
          amt_d   = amt;
          state_d = P1;
        end
      end
      P1: begin
        if (two_pass) begin
          t_d     = bs_b;
          state_d = P2;
        end else begin
          dout_d      = p1_result;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      P2: begin
        dout_d      = t_q | rev(bs_b);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      din_q       <= '0;
      amt_q       <= '0;
      t_q         <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      din_q       <= din_d;
      amt_q       <= amt_d;
      t_q         <= t_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Handshake flags decode from state and reset only.
  always_comb begin
    in_ready  = rst_n & (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = out_valid_q;
    dout      = dout_q;
  end

endmodule
